uart_tx_fifo: RTL and testbench

- Transmit half of the host link: takes bytes from the SoC I/O bus and serialises them onto the board Tx pin.
- Sits directly downstream of the CPU I/O write path inside riscv_top, and directly upstream of the top-level Tx output that the simulation bench and FPGA pin consume.
- Buffers bytes in a small FIFO, so CPU stores do not stall per byte.
- Frame format fixed at 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.

---
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes from the I/O bus queue in a small FIFO
// and are serialised LSB first onto tx, back-to-back frames with no idle gap.
module uart_tx_fifo #(
   parameter int SIM              = 0,
   parameter int CLKS_PER_BIT     = 868,
   parameter int SIM_CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH_LOG2  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   output logic                       full,
   output logic                       empty,
   output logic [FIFO_DEPTH_LOG2:0]   count,
   output logic                       busy,
   output logic                       overflow,
   input  logic                       clr_ovf,
   output logic                       tx
);

   localparam int P     = (SIM != 0) ? SIM_CLKS_PER_BIT : CLKS_PER_BIT;
   localparam int CW    = (P > 1) ? $clog2(P) : 1;
   localparam int LW    = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [CW-1:0] LAST    = CW'(P - 1);
   localparam logic [LW:0]   DEPTH_C = (LW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [DEPTH];
   logic [LW-1:0] wptr_q, rptr_q;
   logic [LW:0]   count_q, count_d;
   logic          full_q, empty_q, ovf_q;
   logic          push, pop;

   state_t        state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   // full is the registered flag, so a same-cycle pop never frees a slot for a write
   assign push = wr_en && !full_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
         // a dropped write wins over a simultaneous clear
         if (wr_en && full_q) ovf_q <= 1'b1;
         else if (clr_ovf)    ovf_q <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty_q) begin
               pop     = 1'b1;
               shift_d = mem[rptr_q];
               cyc_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (cyc_q == LAST) begin
               cyc_d   = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         DATA: begin
            if (cyc_q == LAST) begin
               cyc_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         STOP: begin
            if (cyc_q == LAST) begin
               cyc_d = '0;
               // chain straight into the next start bit when more data waits
               if (!empty_q) begin
                  pop     = 1'b1;
                  shift_d = mem[rptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed frame sequences, and random
// traffic checked against a frame-timeline model plus a serial-line decoder.
module tb_uart_tx_fifo;

   localparam int P  = 4;
   localparam int FL = 10 * P;

   logic       clk = 1'b0;
   logic       rst, wr_en, clr_ovf;
   logic [7:0] wr_data;
   logic       full, empty, busy, overflow, tx;
   logic [3:0] count;

   uart_tx_fifo #(
      .SIM(1), .CLKS_PER_BIT(868), .SIM_CLKS_PER_BIT(P), .FIFO_DEPTH_LOG2(3)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .busy(busy),
      .overflow(overflow), .clr_ovf(clr_ovf), .tx(tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   // model: queue contents, current frame byte and position within its 10*P cycles
   logic [7:0] mq[$];
   logic [7:0] sent[$];
   bit         m_act = 1'b0;
   int         m_t   = 0;
   logic [7:0] m_cur = 8'h00;
   bit         m_ovf = 1'b0;

   // line decoder
   bit         rx_act = 1'b0;
   int         rx_t   = 0;
   logic [7:0] rx_b   = 8'h00;
   logic [7:0] rxq[$];

   logic txl [0:127];
   logic bl  [0:127];
   logic el  [0:127];

   typedef struct {
      bit         r;
      bit         w;
      logic [7:0] d;
      bit         c;
      bit         etx;
      bit         ebusy;
      int         ecnt;
      bit         eempty;
      bit         efull;
      bit         eovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   function automatic logic exp_tx();
      if (!m_act)        return 1'b1;
      if (m_t < P)       return 1'b0;
      if (m_t < 9 * P)   return m_cur[(m_t - P) / P];
      return 1'b1;
   endfunction

   task automatic model_update(input bit r, input bit w, input logic [7:0] d, input bit c);
      bit was_full, do_pop;
      if (r) begin
         mq.delete();
         m_act = 1'b0;
         m_t   = 0;
         m_ovf = 1'b0;
         return;
      end
      was_full = (mq.size() == 8);
      do_pop   = (mq.size() > 0) && (!m_act || m_t == FL - 1);
      if (do_pop) begin
         m_cur = mq.pop_front();
         sent.push_back(m_cur);
         m_act = 1'b1;
         m_t   = 0;
      end else if (m_act) begin
         if (m_t == FL - 1) m_act = 1'b0;
         else               m_t++;
      end
      if (w && was_full)  m_ovf = 1'b1;
      else if (c)         m_ovf = 1'b0;
      if (w && !was_full) mq.push_back(d);
   endtask

   task automatic step(input bit r, input bit w, input logic [7:0] d, input bit c);
      rst = r; wr_en = w; wr_data = d; clr_ovf = c;
      model_update(r, w, d, c);
      @(posedge clk);
      #1;
      cyc++;
      check("m_tx",       tx,       exp_tx());
      check("m_busy",     busy,     m_act);
      check("m_count",    count,    mq.size());
      check("m_empty",    empty,    mq.size() == 0);
      check("m_full",     full,     mq.size() == 8);
      check("m_overflow", overflow, m_ovf);
      if (r) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx === 1'b0) begin
            rx_act = 1'b1;
            rx_t   = 0;
         end
      end else begin
         rx_t++;
         if ((rx_t % P) == P / 2 && rx_t < 9 * P) rx_b[rx_t / P - 1] = tx;
         if (rx_t == 9 * P + P / 2) begin
            check("rx_stop_bit", tx, 1);
            rxq.push_back(rx_b);
            rx_act = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
   endtask

   task automatic drain();
      int g = 0;
      while ((m_act || mq.size() > 0) && g < 3000) begin
         step(0, 0, 8'h00, 0);
         g++;
      end
      check("drain_done", g < 3000, 1);
      idle(3);
   endtask

   initial begin
      vec_t       tbl [12];
      logic [7:0] b;
      int         s1, gaps, g;

      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;

      //            r w d      c  tx busy cnt empty full ovf
      tbl[0]  = '{1, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};
      tbl[1]  = '{1, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};
      tbl[2]  = '{1, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};
      tbl[3]  = '{0, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};
      tbl[4]  = '{0, 1, 8'h55, 0, 1, 0,   1,  0,    0,   0};
      tbl[5]  = '{0, 0, 8'h00, 0, 0, 1,   0,  1,    0,   0};
      tbl[6]  = '{0, 1, 8'hAA, 0, 0, 1,   1,  0,    0,   0};
      tbl[7]  = '{0, 0, 8'h00, 0, 0, 1,   1,  0,    0,   0};
      tbl[8]  = '{0, 0, 8'h00, 0, 0, 1,   1,  0,    0,   0};
      tbl[9]  = '{0, 0, 8'h00, 0, 1, 1,   1,  0,    0,   0};
      tbl[10] = '{1, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};
      tbl[11] = '{0, 0, 8'h00, 0, 1, 0,   0,  1,    0,   0};

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].c);
         check($sformatf("vec%0d_tx", i),    tx,       tbl[i].etx);
         check($sformatf("vec%0d_busy", i),  busy,     tbl[i].ebusy);
         check($sformatf("vec%0d_count", i), count,    tbl[i].ecnt);
         check($sformatf("vec%0d_empty", i), empty,    tbl[i].eempty);
         check($sformatf("vec%0d_full", i),  full,     tbl[i].efull);
         check($sformatf("vec%0d_ovf", i),   overflow, tbl[i].eovf);
      end

      // reset held three cycles, then a quiet line
      for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0);
      for (int i = 0; i < 50; i++) begin
         step(0, 0, 8'h00, 0);
         check("idle_tx", tx, 1);
         check("idle_empty", empty, 1);
         check("idle_full", full, 0);
         check("idle_count", count, 0);
         check("idle_busy", busy, 0);
      end

      // single byte 0x55: exact bit timing relative to the write edge
      rxq.delete();
      step(0, 1, 8'h55, 0);
      for (int k = 1; k <= 45; k++) begin
         step(0, 0, 8'h00, 0);
         txl[k] = tx; bl[k] = busy; el[k] = empty;
      end
      b = 8'h55;
      for (int k = 1; k <= 4; k++) check("single_start", txl[k], 0);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++)
            check($sformatf("single_bit%0d", i), txl[5 + 4 * i + j], b[i]);
      for (int k = 37; k <= 40; k++) check("single_stop", txl[k], 1);
      check("single_busy_n40", bl[40], 1);
      check("single_busy_n41", bl[41], 0);
      check("single_empty_n2", el[2], 1);
      check("single_rx_n", rxq.size(), 1);
      if (rxq.size() >= 1) check("single_rx_byte", rxq[0], 8'h55);

      // back-to-back frames
      rxq.delete();
      step(0, 1, 8'hA3, 0);
      step(0, 1, 8'h0F, 0);
      txl[1] = tx; bl[1] = busy;
      for (int k = 2; k <= 90; k++) begin
         step(0, 0, 8'h00, 0);
         txl[k] = tx; bl[k] = busy;
      end
      s1 = 0;
      for (int k = 90; k >= 1; k--) if (txl[k] === 1'b0 && k <= 10) s1 = k;
      check("b2b_first_start", s1, 1);
      check("b2b_before_second", txl[s1 + 39], 1);
      check("b2b_second_start", txl[s1 + 40], 0);
      gaps = 0;
      for (int k = s1; k < s1 + 2 * FL; k++) if (bl[k] !== 1'b1) gaps++;
      check("b2b_idle_gaps", gaps, 0);
      drain();
      check("b2b_rx_n", rxq.size(), 2);
      if (rxq.size() >= 2) begin
         check("b2b_rx0", rxq[0], 8'hA3);
         check("b2b_rx1", rxq[1], 8'h0F);
      end

      // fill to full while a frame is in flight, then overflow and clear
      rxq.delete();
      for (int i = 0; i < 9; i++) step(0, 1, 8'(i), 0);
      check("fill_full", full, 1);
      check("fill_count", count, 8);
      check("fill_ovf_clear", overflow, 0);
      step(0, 1, 8'h09, 0);
      check("ovf_set", overflow, 1);
      check("ovf_count", count, 8);
      step(0, 0, 8'h00, 1);
      check("ovf_cleared", overflow, 0);

      // write coinciding with the stop-end pop while full
      g = 0;
      while (!(m_act && m_t == FL - 1) && g < 200) begin
         step(0, 0, 8'h00, 0);
         g++;
      end
      check("popwait_done", g < 200, 1);
      check("pop_pre_count", count, 8);
      step(0, 1, 8'hEE, 0);
      check("pop_wr_ovf", overflow, 1);
      check("pop_wr_count", count, 7);
      step(0, 0, 8'h00, 1);
      drain();
      check("fill_rx_n", rxq.size(), 9);
      for (int i = 0; i < 9 && i < rxq.size(); i++)
         check($sformatf("fill_rx%0d", i), rxq[i], i);

      // reset in the middle of data bit 3 of 0xFF
      step(0, 1, 8'hFF, 0);
      g = 0;
      while (!(m_act && m_t == 4 * P + 1) && g < 100) begin
         step(0, 0, 8'h00, 0);
         g++;
      end
      check("midrst_wait_done", g < 100, 1);
      check("midrst_pre_busy", busy, 1);
      step(1, 0, 8'h00, 0);
      check("midrst_tx", tx, 1);
      check("midrst_empty", empty, 1);
      check("midrst_busy", busy, 0);
      rxq.delete();
      sent.delete();
      idle(3);
      step(0, 1, 8'h31, 0);
      drain();
      check("midrst_rx_n", rxq.size(), 1);
      if (rxq.size() >= 1) check("midrst_rx", rxq[0], 8'h31);

      // random traffic against the model
      rxq.delete();
      sent.delete();
      for (int i = 0; i < 1500; i++) begin
         step(0, $urandom_range(0, 99) < 12, 8'($urandom), $urandom_range(0, 19) == 0);
      end
      drain();
      check("rand_rx_n", rxq.size(), sent.size());
      for (int i = 0; i < sent.size() && i < rxq.size(); i++)
         check($sformatf("rand_rx%0d", i), rxq[i], sent[i]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
